// File: rtl/mem_load_pkg.sv
// Shared types and default geometry for the sparse chunk-memory loaders.
// Default geometry: 4-byte beats, 16-byte chunks, 4 chunks.
package mem_load_pkg;

  localparam int BUS_SIZE_DEF  = 4;
  localparam int MEM_SIZE_DEF  = 16;
  localparam int CHUNK_NUM_DEF = 4;

  // Counter width that stays at least 1 bit for degenerate sizes
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEATS       = MEM_SIZE_DEF / BUS_SIZE_DEF;
  localparam int DAT_CNT_W   = cnt_width(BEATS);
  localparam int CHUNK_CNT_W = cnt_width(CHUNK_NUM_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/sparse_compactor.sv
// Combinational sparse encoder: per-byte nonzero map plus left-compacted bytes.
// A prefix sum over the map gives each nonzero byte its output lane.
module sparse_compactor
  import mem_load_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEF
) (
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic [BUS_SIZE*8-1:0] nonzero_data_o
);

  localparam int RANK_W = $clog2(BUS_SIZE + 1);

  logic [BUS_SIZE-1:0]   map_s;
  logic [RANK_W-1:0]     rank_s [BUS_SIZE+1];
  logic [BUS_SIZE*8-1:0] packed_s;

  // Nonzero map, exclusive prefix-sum ranks and one-hot lane selection
  always_comb begin
    map_s    = {BUS_SIZE{1'b0}};
    packed_s = {(BUS_SIZE*8){1'b0}};
    rank_s   = '{default: {RANK_W{1'b0}}};
    for (int k = 0; k < BUS_SIZE; k++) begin
      map_s[k] = |dense_data_i[8*k +: 8];
    end
    for (int k = 0; k < BUS_SIZE; k++) begin
      rank_s[k+1] = rank_s[k] + RANK_W'(map_s[k]);
    end
    for (int j = 0; j < BUS_SIZE; j++) begin
      for (int k = j; k < BUS_SIZE; k++) begin
        packed_s[8*j +: 8] = packed_s[8*j +: 8] |
          ((map_s[k] && (rank_s[k] == RANK_W'(j))) ? dense_data_i[8*k +: 8] : 8'h00);
      end
    end
  end

  assign sparsemap_o    = map_s;
  assign nonzero_data_o = packed_s;

endmodule

// File: rtl/mem_sparse_loader.sv
// Write-side feeder for a chunk memory: sparse-encodes dense beats and
// sequences beat/chunk write addresses for a commanded number of chunks.
module mem_sparse_loader
  import mem_load_pkg::*;
#(
  parameter int BUS_SIZE  = BUS_SIZE_DEF,
  parameter int MEM_SIZE  = MEM_SIZE_DEF,
  parameter int CHUNK_NUM = CHUNK_NUM_DEF,
  localparam int N_BEATS  = MEM_SIZE / BUS_SIZE,
  localparam int DAT_W    = cnt_width(N_BEATS),
  localparam int CHK_W    = cnt_width(CHUNK_NUM),
  localparam int NUM_W    = $clog2(CHUNK_NUM) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NUM_W-1:0]      chunk_num_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  input  logic                  dense_valid_i,
  output logic                  dense_ready_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [DAT_W-1:0]      wr_dat_count_o,
  output logic [CHK_W-1:0]      wr_chunk_count_o
);

  load_state_t           state_r, state_next_s;
  logic [NUM_W-1:0]      chunk_num_r;
  logic [DAT_W-1:0]      beat_r;
  logic [CHK_W-1:0]      chunk_r;
  logic                  accept_s, beat_last_s, chunk_last_s;
  logic [BUS_SIZE-1:0]   enc_map_s;
  logic [BUS_SIZE*8-1:0] enc_data_s;

  logic                  busy_r, done_r, ready_r, wr_valid_r;
  logic [BUS_SIZE-1:0]   wr_map_r;
  logic [BUS_SIZE*8-1:0] wr_data_r;
  logic [DAT_W-1:0]      wr_dat_r;
  logic [CHK_W-1:0]      wr_chunk_r;

  sparse_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
    .dense_data_i   (dense_data_i),
    .sparsemap_o    (enc_map_s),
    .nonzero_data_o (enc_data_s)
  );

  assign accept_s     = dense_valid_i && (state_r == LOAD);
  assign beat_last_s  = (beat_r == DAT_W'(N_BEATS - 1));
  assign chunk_last_s = (NUM_W'(chunk_r) == (chunk_num_r - NUM_W'(1)));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a zero-chunk command completes without any writes
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_next_s = (chunk_num_i != {NUM_W{1'b0}}) ? LOAD : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && beat_last_s && chunk_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = LOAD;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Latched chunk count and beat/chunk write counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chunk_num_r <= {NUM_W{1'b0}};
      beat_r      <= {DAT_W{1'b0}};
      chunk_r     <= {CHK_W{1'b0}};
    end else if ((state_r == IDLE) && start_i) begin
      chunk_num_r <= chunk_num_i;
      beat_r      <= {DAT_W{1'b0}};
      chunk_r     <= {CHK_W{1'b0}};
    end else if (accept_s) begin
      if (beat_last_s) begin
        beat_r  <= {DAT_W{1'b0}};
        chunk_r <= chunk_last_s ? chunk_r : chunk_r + CHK_W'(1);
      end else begin
        beat_r  <= beat_r + DAT_W'(1);
      end
    end
  end

  // Registered status and memory write port; data/counts hold between writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ready_r    <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_map_r   <= {BUS_SIZE{1'b0}};
      wr_data_r  <= {(BUS_SIZE*8){1'b0}};
      wr_dat_r   <= {DAT_W{1'b0}};
      wr_chunk_r <= {CHK_W{1'b0}};
    end else begin
      busy_r     <= (state_next_s == LOAD);
      ready_r    <= (state_next_s == LOAD);
      done_r     <= (state_next_s == DONE);
      wr_valid_r <= accept_s;
      if (accept_s) begin
        wr_map_r   <= enc_map_s;
        wr_data_r  <= enc_data_s;
        wr_dat_r   <= beat_r;
        wr_chunk_r <= chunk_r;
      end
    end
  end

  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign dense_ready_o     = ready_r;
  assign wr_valid_o        = wr_valid_r;
  assign wr_sparsemap_o    = wr_map_r;
  assign wr_nonzero_data_o = wr_data_r;
  assign wr_dat_count_o    = wr_dat_r;
  assign wr_chunk_count_o  = wr_chunk_r;

endmodule

// File: tb/tb_mem_sparse_loader.sv
// Directed bench for mem_sparse_loader with 4-byte beats, 4 beats/chunk, 4 chunks.
module tb_mem_sparse_loader;

  logic        clk = 1'b0;
  logic        rst_i, start_i, dense_valid_i;
  logic [2:0]  chunk_num_i;
  logic [31:0] dense_data_i;
  logic        busy_o, done_o, dense_ready_o, wr_valid_o;
  logic [3:0]  wr_sparsemap_o;
  logic [31:0] wr_nonzero_data_o;
  logic [1:0]  wr_dat_count_o, wr_chunk_count_o;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int w0, d0;

  mem_sparse_loader #(.BUS_SIZE(4), .MEM_SIZE(16), .CHUNK_NUM(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .chunk_num_i(chunk_num_i),
    .busy_o(busy_o), .done_o(done_o), .dense_data_i(dense_data_i),
    .dense_valid_i(dense_valid_i), .dense_ready_o(dense_ready_o),
    .wr_sparsemap_o(wr_sparsemap_o), .wr_nonzero_data_o(wr_nonzero_data_o),
    .wr_valid_o(wr_valid_o), .wr_dat_count_o(wr_dat_count_o),
    .wr_chunk_count_o(wr_chunk_count_o)
  );

  always #5 clk = ~clk;

  // Count writes and done pulses away from the active edge
  always @(negedge clk) begin
    if (wr_valid_o) wr_cnt++;
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, let it be accepted, then check the write it produces
  task automatic beat(input logic [31:0] d, input logic [3:0] m, input logic [31:0] nz,
                      input int dc, input int cc, input logic dn);
    dense_data_i  = d;
    dense_valid_i = 1'b1;
    cyc();
    chk("wr_valid", 64'(wr_valid_o), 64'd1);
    chk("map", 64'(wr_sparsemap_o), 64'(m));
    chk("data", 64'(wr_nonzero_data_o), 64'(nz));
    chk("dat_count", 64'(wr_dat_count_o), 64'(dc));
    chk("chunk_count", 64'(wr_chunk_count_o), 64'(cc));
    chk("done", 64'(done_o), 64'(dn));
  endtask

  initial begin
    logic [7:0] b;
    rst_i = 1'b1; start_i = 1'b0; chunk_num_i = 3'd0;
    dense_valid_i = 1'b1; dense_data_i = 32'h5A5A5A5A;

    // Reset held 3 cycles with valid asserted
    repeat (3) cyc();
    chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ready", 64'(dense_ready_o), 64'd0);
    chk("rst_map", 64'(wr_sparsemap_o), 64'd0);
    chk("rst_data", 64'(wr_nonzero_data_o), 64'd0);
    chk("rst_counts", 64'({wr_dat_count_o, wr_chunk_count_o}), 64'd0);
    rst_i = 1'b0;
    cyc();
    chk("idle_valid_ignored", 64'(wr_valid_o), 64'd0);
    chk("idle_ready", 64'(dense_ready_o), 64'd0);
    dense_valid_i = 1'b0;

    // One chunk, directed encodings
    chunk_num_i = 3'd1; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("load_busy", 64'(busy_o), 64'd1);
    chk("load_ready", 64'(dense_ready_o), 64'd1);
    beat(32'h07000500, 4'b1010, 32'h00000705, 0, 0, 1'b0);
    beat(32'h44332211, 4'b1111, 32'h44332211, 1, 0, 1'b0);
    beat(32'h00000000, 4'b0000, 32'h00000000, 2, 0, 1'b0);
    beat(32'h01000080, 4'b1001, 32'h00000180, 3, 0, 1'b1);
    dense_valid_i = 1'b0;
    chk("done_busy", 64'(busy_o), 64'd0);
    cyc();
    chk("post_done", 64'(done_o), 64'd0);
    chk("post_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("hold_map", 64'(wr_sparsemap_o), 64'h9);
    chk("hold_data", 64'(wr_nonzero_data_o), 64'h180);
    chk("hold_dat", 64'(wr_dat_count_o), 64'd3);

    // Three chunks, valid every other cycle
    w0 = wr_cnt;
    chunk_num_i = 3'd3; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        b = 8'(i + 1);
        beat({8'h00, b, 16'h0000}, 4'b0100, {24'h0, b}, i % 4, i / 4, i == 11);
      end else begin
        b = 8'(i);
        beat({8'hA0, 16'h0000, b}, 4'b1001, {16'h0, 8'hA0, b}, i % 4, i / 4, i == 11);
      end
      dense_valid_i = 1'b0;
      cyc();
      chk("gap_no_write", 64'(wr_valid_o), 64'd0);
      chk("gap_hold_dat", 64'(wr_dat_count_o), 64'(i % 4));
    end
    chk("three_chunk_writes", 64'(wr_cnt - w0), 64'd12);
    chk("three_chunk_busy", 64'(busy_o), 64'd0);
    chk("three_chunk_done_low", 64'(done_o), 64'd0);

    // Zero-chunk command
    w0 = wr_cnt;
    chunk_num_i = 3'd0; start_i = 1'b1;
    dense_valid_i = 1'b1; dense_data_i = 32'h11111111;
    cyc();
    start_i = 1'b0;
    chk("zero_done", 64'(done_o), 64'd1);
    chk("zero_busy", 64'(busy_o), 64'd0);
    chk("zero_ready", 64'(dense_ready_o), 64'd0);
    chk("zero_wr_valid", 64'(wr_valid_o), 64'd0);
    cyc();
    chk("zero_done_pulse", 64'(done_o), 64'd0);
    chk("zero_ready2", 64'(dense_ready_o), 64'd0);
    chk("zero_wr_valid2", 64'(wr_valid_o), 64'd0);
    dense_valid_i = 1'b0;
    chk("zero_writes", 64'(wr_cnt - w0), 64'd0);

    // start mid-load is ignored
    w0 = wr_cnt;
    chunk_num_i = 3'd1; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    beat(32'h000000FF, 4'b0001, 32'h000000FF, 0, 0, 1'b0);
    start_i = 1'b1; chunk_num_i = 3'd2;
    beat(32'hFF000000, 4'b1000, 32'h000000FF, 1, 0, 1'b0);
    start_i = 1'b0;
    beat(32'h12003400, 4'b1010, 32'h00001234, 2, 0, 1'b0);
    beat(32'h00000000, 4'b0000, 32'h00000000, 3, 0, 1'b1);
    dense_valid_i = 1'b0;
    cyc();
    chk("restart_done_low", 64'(done_o), 64'd0);
    chk("restart_busy", 64'(busy_o), 64'd0);
    chk("restart_writes", 64'(wr_cnt - w0), 64'd4);

    // Reset after the 6th beat of a 3-chunk load
    d0 = done_cnt;
    chunk_num_i = 3'd3; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat(32'(i + 1), 4'b0001, 32'(i + 1), i % 4, i / 4, 1'b0);
    end
    rst_i = 1'b1; dense_data_i = 32'h00000077;
    cyc();
    chk("midrst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_ready", 64'(dense_ready_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk("midrst_map", 64'(wr_sparsemap_o), 64'd0);
    rst_i = 1'b0; dense_valid_i = 1'b0;
    cyc();
    cyc();
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chunk_num_i = 3'd1; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    beat(32'h00000009, 4'b0001, 32'h00000009, 0, 0, 1'b0);
    beat(32'h00000A00, 4'b0010, 32'h0000000A, 1, 0, 1'b0);
    beat(32'h0B000C00, 4'b1010, 32'h00000B0C, 2, 0, 1'b0);
    beat(32'h0D0E0F10, 4'b1111, 32'h0D0E0F10, 3, 0, 1'b1);
    dense_valid_i = 1'b0;
    cyc();
    chk("final_idle_busy", 64'(busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sparse_loader.md
Name: mem_sparse_loader

Overview:
- Write-side feeder for the IFM and filter chunk memories; one instance per memory.
- Accepts a dense byte stream and sparse-encodes each BUS_SIZE-byte beat into a sparsemap (bit=1 where the byte is nonzero) plus left-compacted nonzero bytes.
- Drives the memory write port (sparsemap, nonzero data, valid, dat_count, chunk_count) and sequences beats and chunks for a commanded number of chunks.

Parameters:
- BUS_SIZE, `BUS_SIZE: bytes per beat and sparsemap width.
- MEM_SIZE, `MEM_SIZE: bytes per chunk. Beats per chunk BEATS = MEM_SIZE/BUS_SIZE; MEM_SIZE must be a multiple of BUS_SIZE.
- CHUNK_NUM, `MEM_SIZE/`CHANNEL_NUM + `OUTPUT_BUF_NUM: maximum chunks per load (memory depth).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- start_i  in  1  load command, accepted only in IDLE.
- chunk_num_i  in  $clog2(CHUNK_NUM)+1  number of chunks to load, sampled with start_i.
- busy_o  out  1  high in LOAD.
- done_o  out  1  one-cycle pulse at load completion.
- dense_data_i  in  BUS_SIZE*8  dense beat; byte k is bits [8k+7:8k].
- dense_valid_i  in  1  beat valid.
- dense_ready_o  out  1  beat accepted when valid & ready.
- wr_sparsemap_o  out  BUS_SIZE  to memory wr_sparsemap_i.
- wr_nonzero_data_o  out  BUS_SIZE*8  to memory wr_nonzero_data_i.
- wr_valid_o  out  1  to memory wr_valid_i.
- wr_dat_count_o  out  $clog2(BEATS)  beat index within chunk.
- wr_chunk_count_o  out  $clog2(CHUNK_NUM)  chunk index.

Behaviour:
- Single clock clk_i; rst_i synchronous, active-high.
- Reset: state=IDLE; all outputs 0, including the wr_* outputs, busy_o, done_o and dense_ready_o.
- FSM states IDLE, LOAD, DONE:
  - IDLE -> LOAD on start_i with chunk_num_i != 0. chunk_num_i is latched and the beat/chunk counters are cleared.
  - IDLE -> DONE on start_i with chunk_num_i == 0. No writes are issued.
  - LOAD -> DONE on acceptance of the last beat (beat == BEATS-1 and chunk == latched-1).
  - DONE -> IDLE unconditionally. done_o=1 only in DONE.
- dense_ready_o = (state==LOAD). Memory never backpressures.
- start_i outside IDLE is ignored. The latched count does not change.
- Encoding (combinational, in sparse_compactor):
  - sparsemap[k] = |byte[k].
  - Nonzero byte with rank r (count of nonzero bytes below k) is placed in output lane r.
  - Lanes >= popcount are 0. An all-zero beat gives map 0, data 0.
- Output stage registered: latency exactly 1 cycle from the accepting edge to wr_valid_o=1 with encoded data and the counts of that beat.
  - wr_valid_o=0 in cycles with no acceptance.
  - wr_* data/count holds its last value when wr_valid_o=0.
- Counters advance only on acceptance:
  - beat wraps BEATS-1 -> 0 and increments chunk.
  - chunk never exceeds latched-1.
- The last beat's write (wr_valid_o) and done_o occur in the same cycle.
- rst_i mid-LOAD: immediate return to IDLE, counters cleared, no done_o; an in-flight write is dropped.
- dense_valid_i while not LOAD: ignored, no write.

Decomposition:
- Shared package mem_load_pkg:
  - typedef enum {IDLE, LOAD, DONE} load_state_t.
  - localparams BEATS, DAT_CNT_W, CHUNK_CNT_W.
- Sub-module sparse_compactor: purely combinational BUS_SIZE-lane prefix-sum compaction, producing the sparsemap and packed data. It is reused later by the on-chip output re-encoder.

Test Plan (BUS_SIZE=4, MEM_SIZE=16 so BEATS=4, CHUNK_NUM=4):
- Reset held 3 cycles with dense_valid_i=1 -> all outputs 0, no write, state IDLE.
- start_i, chunk_num_i=1; beats {00,05,00,07}, {11,22,33,44}, {00,00,00,00}, {80,00,00,01} (byte0 first):
  - maps 1010, 1111, 0000, 1001.
  - data lanes {05,07,00,00}, {11,22,33,44}, {00,00,00,00}, {80,01,00,00}.
  - dat_count 0..3, chunk_count 0.
  - done_o on the 4th write cycle.
- chunk_num_i=3, 12 beats with valid toggled every other cycle:
  - writes only 1 cycle after acceptances.
  - dat_count wraps 3->0 while chunk_count goes 0->1->2.
  - exactly 12 writes; busy_o low after done.
- start_i with chunk_num_i=0 -> done_o next cycle, no wr_valid_o, dense_ready_o stays 0.
- start_i pulsed again mid-load with chunk_num_i=2 while loading 1 chunk -> ignored; exactly 4 writes, then done.
- rst_i asserted after the 6th beat of a 3-chunk load -> no done_o; the next load starts at chunk_count 0, dat_count 0.
